// File: rtl/micro_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : micro_seq_ctrl
// Brief    : Microprogrammed control unit for the multicycle MIPS datapath.
//            Microcode ROM, two opcode dispatch ROMs, and a micro-PC sequencer.
//            Memory states stretch on MemReady, and a sticky timeout flags
//            long stalls.
// Revision : 1.0 - initial release
// ============================================================================
module micro_seq_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       MemReady,
    output logic [3:0] S,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic       Illegal,
    output logic       InstrDone,
    output logic       MemTimeout
);

    // Sequencing modes held in the microword
    localparam logic [1:0] c_addr_fetch = 2'b00;
    localparam logic [1:0] c_addr_disp1 = 2'b01;
    localparam logic [1:0] c_addr_disp2 = 2'b10;
    localparam logic [1:0] c_addr_seq   = 2'b11;

    // Micro-PC values
    localparam logic [3:0] c_st_fetch   = 4'd0;
    localparam logic [3:0] c_st_decode  = 4'd1;
    localparam logic [3:0] c_st_memaddr = 4'd2;
    localparam logic [3:0] c_st_memrd   = 4'd3;
    localparam logic [3:0] c_st_ldwb    = 4'd4;
    localparam logic [3:0] c_st_memwr   = 4'd5;
    localparam logic [3:0] c_st_rexec   = 4'd6;
    localparam logic [3:0] c_st_rdone   = 4'd7;
    localparam logic [3:0] c_st_branch  = 4'd8;
    localparam logic [3:0] c_st_jump    = 4'd9;

    // Opcodes understood by the dispatch ROMs
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // Stall counter saturates at the limit, so it needs to represent WAIT_LIMIT
    localparam int              c_cnt_w    = $clog2(WAIT_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit    = c_cnt_w'(WAIT_LIMIT);
    localparam logic [c_cnt_w-1:0] c_limit_m1 = c_cnt_w'(WAIT_LIMIT - 1);

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memto_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] addr_ctl;
    } uword_t;

    logic [3:0]         r_upc;
    logic [3:0]         w_upc_next;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_timeout;
    uword_t             w_uword;
    logic [3:0]         w_disp1;
    logic [3:0]         w_disp2;
    logic               w_op_illegal;
    logic               w_mem_state;
    logic               w_stall;

    // Microcode ROM; unused micro-PC values fall back to a fetch redirect
    always_comb begin
        w_uword = '0;
        case (r_upc)
            c_st_fetch: begin
                w_uword.mem_read  = 1'b1;
                w_uword.ir_write  = 1'b1;
                w_uword.alu_src_b = 2'b01;
                w_uword.pc_write  = 1'b1;
                w_uword.pc_source = 2'b00;
                w_uword.addr_ctl  = c_addr_seq;
            end
            c_st_decode: begin
                w_uword.alu_src_b = 2'b11;
                w_uword.addr_ctl  = c_addr_disp1;
            end
            c_st_memaddr: begin
                w_uword.alu_src_a = 1'b1;
                w_uword.alu_src_b = 2'b10;
                w_uword.addr_ctl  = c_addr_disp2;
            end
            c_st_memrd: begin
                w_uword.mem_read = 1'b1;
                w_uword.ior_d    = 1'b1;
                w_uword.addr_ctl = c_addr_seq;
            end
            c_st_ldwb: begin
                w_uword.reg_write = 1'b1;
                w_uword.memto_reg = 1'b1;
                w_uword.addr_ctl  = c_addr_fetch;
            end
            c_st_memwr: begin
                w_uword.mem_write = 1'b1;
                w_uword.ior_d     = 1'b1;
                w_uword.addr_ctl  = c_addr_fetch;
            end
            c_st_rexec: begin
                w_uword.alu_src_a = 1'b1;
                w_uword.alu_op    = 2'b10;
                w_uword.addr_ctl  = c_addr_seq;
            end
            c_st_rdone: begin
                w_uword.reg_write = 1'b1;
                w_uword.reg_dst   = 1'b1;
                w_uword.addr_ctl  = c_addr_fetch;
            end
            c_st_branch: begin
                w_uword.alu_src_a     = 1'b1;
                w_uword.alu_op        = 2'b01;
                w_uword.pc_write_cond = 1'b1;
                w_uword.pc_source     = 2'b01;
                w_uword.addr_ctl      = c_addr_fetch;
            end
            c_st_jump: begin
                w_uword.pc_write  = 1'b1;
                w_uword.pc_source = 2'b10;
                w_uword.addr_ctl  = c_addr_fetch;
            end
            default: w_uword = '0;
        endcase
    end

    // Dispatch ROM 1: decode-state branch on opcode, flags unsupported opcodes
    always_comb begin
        w_disp1      = c_st_fetch;
        w_op_illegal = 1'b0;
        case (Op)
            c_op_rtype: w_disp1 = c_st_rexec;
            c_op_lw:    w_disp1 = c_st_memaddr;
            c_op_sw:    w_disp1 = c_st_memaddr;
            c_op_beq:   w_disp1 = c_st_branch;
            c_op_j:     w_disp1 = c_st_jump;
            default:    w_op_illegal = 1'b1;
        endcase
    end

    // Dispatch ROM 2: load/store split after the address computation
    always_comb begin
        w_disp2 = c_st_fetch;
        case (Op)
            c_op_lw: w_disp2 = c_st_memrd;
            c_op_sw: w_disp2 = c_st_memwr;
            default: w_disp2 = c_st_fetch;
        endcase
    end

    assign w_mem_state = (r_upc == c_st_fetch) || (r_upc == c_st_memrd) ||
                         (r_upc == c_st_memwr);
    assign w_stall     = w_mem_state && !MemReady;

    // Next micro-PC: hold while memory is busy, otherwise follow AddrCtl
    always_comb begin
        w_upc_next = c_st_fetch;
        if (w_stall) begin
            w_upc_next = r_upc;
        end else begin
            case (w_uword.addr_ctl)
                c_addr_fetch: w_upc_next = c_st_fetch;
                c_addr_disp1: w_upc_next = w_disp1;
                c_addr_disp2: w_upc_next = w_disp2;
                c_addr_seq:   w_upc_next = r_upc + 4'd1;
                default:      w_upc_next = c_st_fetch;
            endcase
        end
    end

    // Micro-PC register
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_upc <= c_st_fetch;
        end else begin
            r_upc <= w_upc_next;
        end
    end

    // Consecutive-stall counter and sticky timeout; the access is never aborted
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_stall) begin
            if (r_wait_cnt != c_limit) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt >= c_limit_m1) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // Output decode: reset masks everything, stalls suppress PC/IR writes
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        Illegal     = 1'b0;
        InstrDone   = 1'b0;
        if (reset) begin
            PCWrite     = w_uword.pc_write & ~w_stall;
            PCWriteCond = w_uword.pc_write_cond;
            IorD        = w_uword.ior_d;
            MemRead     = w_uword.mem_read;
            MemWrite    = w_uword.mem_write;
            IRWrite     = w_uword.ir_write & ~w_stall;
            MemtoReg    = w_uword.memto_reg;
            ALUSrcA     = w_uword.alu_src_a;
            RegWrite    = w_uword.reg_write;
            RegDst      = w_uword.reg_dst;
            PCSource    = w_uword.pc_source;
            ALUOp       = w_uword.alu_op;
            ALUSrcB     = w_uword.alu_src_b;
            Illegal     = (r_upc == c_st_decode) & w_op_illegal;
            case (r_upc)
                c_st_ldwb, c_st_rdone, c_st_branch, c_st_jump: InstrDone = 1'b1;
                c_st_memwr:  InstrDone = MemReady;
                c_st_decode: InstrDone = w_op_illegal;
                default:     InstrDone = 1'b0;
            endcase
        end
    end

    assign S          = r_upc;
    assign MemTimeout = r_timeout;

endmodule
`default_nettype wire

// File: doc/micro_seq_ctrl.md
# micro_seq_ctrl

Microprogrammed control unit for the multicycle MIPS datapath. It replaces hardwired next-state logic with a microcode ROM, two dispatch ROMs and a micro-PC sequencer. It adds a memory wait-state handshake so that fetch and data accesses can stretch over several cycles. It sits between the instruction register's opcode field and the datapath's mux selects and write enables. Its control-signal names and encodings match the existing multicycle controller.

## Interface
- WAIT_LIMIT, 15: consecutive MemReady-low cycles in one memory state before MemTimeout sets.
- Clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; low forces the idle/reset condition immediately.
- Op  input  6  opcode from IR[31:26]; stable from state 1 until the instruction retires.
- MemReady  input  1  memory completes the current access this cycle.
- S  output  4  current micro-PC (state number 0–9).
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
- PCSource, ALUOp, ALUSrcB  output  2 each  datapath mux and ALU controls.
- Illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.
- InstrDone  output  1  one-cycle pulse in the final cycle of each retired instruction.
- MemTimeout  output  1  sticky wait-limit error flag.

## Operation
- Microword fields are the 16 control bits plus AddrCtl[1:0]. AddrCtl encodings:
  - 00: next state is 0 (fetch).
  - 01: next state from dispatch ROM 1, indexed by Op.
  - 10: next state from dispatch ROM 2, indexed by Op.
  - 11: next state is micro-PC + 1.
- Microcode contents. Any control not listed is 0.
  - State 0, fetch: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1, PCSource=00. AddrCtl=11.
  - State 1, decode: ALUSrcB=11. AddrCtl=01.
  - State 2, memory address: ALUSrcA=1, ALUSrcB=10. AddrCtl=10.
  - State 3, memory read: MemRead=1, IorD=1. AddrCtl=11.
  - State 4, load writeback: RegWrite=1, MemtoReg=1. AddrCtl=00.
  - State 5, memory write: MemWrite=1, IorD=1. AddrCtl=00.
  - State 6, R-type execute: ALUSrcA=1, ALUOp=10. AddrCtl=11.
  - State 7, R-type completion: RegWrite=1, RegDst=1. AddrCtl=00.
  - State 8, branch: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. AddrCtl=00.
  - State 9, jump: PCWrite=1, PCSource=10. AddrCtl=00.
- Dispatch ROM 1:
  - 000000 → 6.
  - 100011 → 2.
  - 101011 → 2.
  - 000100 → 8.
  - 000010 → 9.
  - Any other opcode → 0, with Illegal=1 during state 1.
- Dispatch ROM 2:
  - 100011 → 3.
  - 101011 → 5.
  - Any other opcode → 0. This case is unreachable.
- Memory states are 0, 3 and 5. While MemReady=0 in a memory state:
  - The micro-PC holds.
  - MemRead, MemWrite and IorD stay asserted.
  - PCWrite and IRWrite are gated to 0. They assert only in the cycle where MemReady=1.
- All non-memory states ignore MemReady.
- InstrDone=1 in states 4, 5, 7, 8 and 9, qualified by MemReady in state 5. It also pulses in state 1 when Illegal=1.
- Wait counter:
  - Counts consecutive stalled cycles. It clears on any state change.
  - MemTimeout sets when the count reaches WAIT_LIMIT.
  - MemTimeout stays set until reset. The sequencer keeps waiting; it does not abort the access.
- Unused micro-PC values 10–15 decode to all-zero controls with AddrCtl=00, so the sequencer recovers to state 0.

## Timing
- Reset low:
  - S=0 and the wait counter is 0; MemTimeout is 0.
  - Every control output, Illegal and InstrDone are forced to 0, overriding the state-0 microword.
- After reset is released, the fetch controls appear combinationally in state 0.
- Outputs are Moore-style from the micro-PC and MemReady only. Op affects the next state only, apart from Illegal.
- Cycle counts with MemReady=1 throughout:
  - lw: 5 cycles (0, 1, 2, 3, 4).
  - sw: 4 cycles (0, 1, 2, 5).
  - R-type: 4 cycles (0, 1, 6, 7).
  - beq: 3 cycles (0, 1, 8).
  - j: 3 cycles (0, 1, 9).
  - Illegal opcode: 2 cycles (0, 1).
- Each stalled cycle in a memory state adds exactly one cycle.
- Reset asserted mid-instruction: the sequencer returns to state 0 immediately and discards any partial instruction.

## Test plan
- Reset released with Op=100011 and MemReady=1 → S follows 0, 1, 2, 3, 4, 0 on successive edges. In state 0, PCWrite=1, IRWrite=1 and ALUSrcB=01. In state 4, RegWrite=1, MemtoReg=1 and InstrDone=1.
- Op=000000, then 101011, 000100, 000010 → paths 0-1-6-7, 0-1-2-5, 0-1-8 and 0-1-9. Check ALUOp=10 in state 6, PCWriteCond=1 with PCSource=01 in state 8, and PCSource=10 in state 9.
- Op=111111 → Illegal=1 for exactly one cycle in state 1, then S=0. No RegWrite, MemWrite or PCWriteCond is asserted.
- MemReady=0 for 3 cycles in state 0 → S stays 0 for 4 cycles with MemRead=1 throughout. PCWrite and IRWrite are high only in the 4th cycle. Repeat in state 3: S stays 3 and IorD=1.
- MemReady held at 0 for 15 cycles in state 5 → MemTimeout rises after the 15th stalled cycle and stays high after MemReady returns. It clears only on reset.
- reset driven low mid-cycle in state 6 → S=0 and all outputs are 0 immediately, without waiting for a clock edge. After release, the next instruction starts from fetch.
